// File: rtl/reg_bank_ctx.sv
// reg_bank_ctx: NREGS x WIDTH CPU register bank with a stack pointer, a masked
// flag register and a shadow bank. The shadow bank is filled or drained one
// register per cycle by a small context engine used on interrupt entry/exit.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   rd_sel_a/b, rd_data_a/b  two combinational read ports
//   wr_en, wr_sel, wr_data   single write port (accepted only when idle)
//   sp_inc, sp_dec, sp_out   stack pointer step and current value
//   flag_we, flag_in,
//   flag_mask, flags_out     masked flag update and current flags
//   ctx_save, ctx_restore    start live->shadow / shadow->live copy
//   ctx_busy, ctx_done       copy in progress / one-cycle completion pulse
module reg_bank_ctx #(
  parameter int WIDTH    = 16,
  parameter int NREGS    = 8,
  parameter int SP_IDX   = 3,
  parameter int SP_RESET = 'hFF00,
  parameter int FLAG_W   = 4,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(NREGS)-1:0]   rd_sel_a,
  output logic [WIDTH-1:0]           rd_data_a,
  input  logic [$clog2(NREGS)-1:0]   rd_sel_b,
  output logic [WIDTH-1:0]           rd_data_b,
  input  logic                       wr_en,
  input  logic [$clog2(NREGS)-1:0]   wr_sel,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       sp_inc,
  input  logic                       sp_dec,
  output logic [WIDTH-1:0]           sp_out,
  input  logic                       flag_we,
  input  logic [FLAG_W-1:0]          flag_in,
  input  logic [FLAG_W-1:0]          flag_mask,
  output logic [FLAG_W-1:0]          flags_out,
  input  logic                       ctx_save,
  input  logic                       ctx_restore,
  output logic                       ctx_busy,
  output logic                       ctx_done
);
  localparam int              AW     = $clog2(NREGS);
  localparam logic [WIDTH-1:0] SP_RST = WIDTH'(SP_RESET);
  localparam logic [AW-1:0]    SP_SEL = AW'(SP_IDX);
  localparam logic [AW-1:0]    LAST   = AW'(NREGS - 1);
  localparam bit               BYP    = (BYPASS != 0);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t                      state;
  logic [AW-1:0]               idx;
  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0][WIDTH-1:0] shadow;
  logic [FLAG_W-1:0]           flags;
  logic [FLAG_W-1:0]           shadow_flags;
  logic                        wr_ok;
  logic                        sp_wr;

  // Writes (and therefore bypass) only take effect while the engine is idle.
  assign wr_ok    = wr_en && (state == IDLE);
  assign sp_wr    = wr_en && (wr_sel == SP_SEL);
  assign ctx_busy = (state != IDLE);
  assign sp_out   = regs[SP_IDX];
  assign flags_out = flags;

  always_comb begin
    rd_data_a = regs[rd_sel_a];
    rd_data_b = regs[rd_sel_b];
    if (BYP && wr_ok && (wr_sel == rd_sel_a)) rd_data_a = wr_data;
    if (BYP && wr_ok && (wr_sel == rd_sel_b)) rd_data_b = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i]   <= (i == SP_IDX) ? SP_RST : '0;
        shadow[i] <= (i == SP_IDX) ? SP_RST : '0;
      end
      flags        <= '0;
      shadow_flags <= '0;
      state        <= IDLE;
      idx          <= '0;
      ctx_done     <= 1'b0;
    end else begin
      ctx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en) regs[wr_sel] <= wr_data;
          // A direct SP write wins over inc/dec; inc and dec together cancel.
          if (!sp_wr && (sp_inc ^ sp_dec))
            regs[SP_IDX] <= sp_inc ? regs[SP_IDX] + 1'b1 : regs[SP_IDX] - 1'b1;
          if (flag_we) flags <= (flags & ~flag_mask) | (flag_in & flag_mask);
          if (ctx_save) begin
            state <= SAVE;
            idx   <= '0;
          end else if (ctx_restore) begin
            state <= RESTORE;
            idx   <= '0;
          end
        end
        SAVE: begin
          shadow[idx] <= regs[idx];
          idx         <= idx + 1'b1;
          if (idx == LAST) begin
            shadow_flags <= flags;
            state        <= IDLE;
            ctx_done     <= 1'b1;
          end
        end
        RESTORE: begin
          regs[idx] <= shadow[idx];
          idx       <= idx + 1'b1;
          if (idx == LAST) begin
            flags    <= shadow_flags;
            state    <= IDLE;
            ctx_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_bank_ctx.sv
module tb_reg_bank_ctx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rd_sel_a, rd_sel_b, wr_sel;
  logic [15:0] wr_data;
  logic        wr_en, sp_inc, sp_dec, flag_we, ctx_save, ctx_restore;
  logic [3:0]  flag_in, flag_mask;

  logic [15:0] rd_data_a, rd_data_b, sp_out;
  logic [3:0]  flags_out;
  logic        ctx_busy, ctx_done;
  logic [15:0] rd_data_a0, rd_data_b0, sp_out0;
  logic [3:0]  flags_out0;
  logic        ctx_busy0, ctx_done0;

  reg_bank_ctx #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a),
    .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_out(sp_out),
    .flag_we(flag_we), .flag_in(flag_in), .flag_mask(flag_mask), .flags_out(flags_out),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_busy(ctx_busy), .ctx_done(ctx_done));

  reg_bank_ctx #(.BYPASS(0)) dut0 (
    .clk(clk), .rst(rst), .rd_sel_a(rd_sel_a), .rd_data_a(rd_data_a0),
    .rd_sel_b(rd_sel_b), .rd_data_b(rd_data_b0), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .sp_inc(sp_inc), .sp_dec(sp_dec), .sp_out(sp_out0),
    .flag_we(flag_we), .flag_in(flag_in), .flag_mask(flag_mask), .flags_out(flags_out0),
    .ctx_save(ctx_save), .ctx_restore(ctx_restore), .ctx_busy(ctx_busy0), .ctx_done(ctx_done0));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        inc, dec, fwe;
    logic [3:0]  fin, fmask;
    logic [2:0]  ra, rb;
    logic [15:0] ea, eb, ea0, esp;
    logic [3:0]  efl;
  } vec_t;

  typedef struct {
    int          kind;  // 0 sp, 1 flags, 2 busy, 3 done
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t        tbl[12];
  sb_t         sbq[$];
  logic [15:0] e_rst[8], v11[8], vee[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      0:       return {16'h0, sp_out};
      1:       return {28'h0, flags_out};
      2:       return {31'h0, ctx_busy};
      default: return {31'h0, ctx_done};
    endcase
  endfunction

  task automatic expect_after(input int kind, input logic [31:0] e, input string n);
    sb_t s;
    s.kind = kind; s.exp = e; s.name = n;
    sbq.push_back(s);
  endtask

  // Advance past the next active edge and retire everything queued for it.
  task automatic tick();
    sb_t s;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      check(s.name, observe(s.kind), s.exp);
    end
  endtask

  task automatic idle_in();
    wr_en = 0; wr_sel = 0; wr_data = 0; sp_inc = 0; sp_dec = 0;
    flag_we = 0; flag_in = 0; flag_mask = 0; ctx_save = 0; ctx_restore = 0;
    rd_sel_a = 0; rd_sel_b = 0;
  endtask

  task automatic read_all(input logic [15:0] e [8], input string n);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_in();
      rd_sel_a = 3'(i);
      rd_sel_b = 3'(7 - i);
      #1;
      check({n, "_a"}, {16'h0, rd_data_a}, {16'h0, e[i]});
      check({n, "_b"}, {16'h0, rd_data_b}, {16'h0, e[7 - i]});
    end
  endtask

  task automatic write_all(input logic [15:0] v [8]);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      idle_in();
      wr_en = 1; wr_sel = 3'(i); wr_data = v[i];
    end
    @(negedge clk);
    idle_in();
  endtask

  // Pulse save/restore, check busy for 8 edges and done on the 9th, while
  // hammering every input that must be dropped during the copy.
  task automatic run_ctx(input bit sv, input bit rs, input logic [15:0] r5, input string n);
    @(negedge clk);
    idle_in();
    ctx_save = sv; ctx_restore = rs;
    for (int k = 0; k < 10; k++) begin
      expect_after(2, (k < 8) ? 32'd1 : 32'd0, {n, "_busy"});
      expect_after(3, (k == 8) ? 32'd1 : 32'd0, {n, "_done"});
      tick();
      @(negedge clk);
      idle_in();
      if (k < 8) begin
        wr_en = 1; wr_sel = 3'd5; wr_data = 16'hDEAD; sp_inc = 1;
        flag_we = 1; flag_in = 4'hF; flag_mask = 4'hF;
        ctx_save = 1; ctx_restore = 1; rd_sel_a = 3'd5;
        #1;
        if (k < 5) check({n, "_nobyp"}, {16'h0, rd_data_a}, {16'h0, r5});
      end
      if (k == 7) begin
        // ctx inputs must not be live after the engine returns to idle
        ctx_save = 0; ctx_restore = 0;
      end
    end
    @(negedge clk);
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      e_rst[i] = (i == 3) ? 16'hFF00 : 16'h0000;
      v11[i]   = 16'(16'h11 * i);
      vee[i]   = 16'(16'hEE00 + i);
    end
    //          we sel wdata    inc dec fwe fin   fmask ra rb ea       eb       ea0      esp      efl
    tbl[0]  = '{0, 0, 16'h0000, 0,  0,  0,  4'h0, 4'h0, 0, 3, 16'h0000,16'hFF00,16'h0000,16'hFF00,4'h0};
    tbl[1]  = '{1, 1, 16'h1234, 0,  0,  0,  4'h0, 4'h0, 1, 1, 16'h1234,16'h1234,16'h0000,16'hFF00,4'h0};
    tbl[2]  = '{0, 0, 16'h0000, 0,  0,  0,  4'h0, 4'h0, 1, 0, 16'h1234,16'h0000,16'h1234,16'hFF00,4'h0};
    tbl[3]  = '{1, 3, 16'hFFFF, 0,  0,  0,  4'h0, 4'h0, 3, 3, 16'hFFFF,16'hFFFF,16'hFF00,16'hFFFF,4'h0};
    tbl[4]  = '{0, 0, 16'h0000, 1,  0,  0,  4'h0, 4'h0, 3, 3, 16'hFFFF,16'hFFFF,16'hFFFF,16'h0000,4'h0};
    tbl[5]  = '{0, 0, 16'h0000, 0,  1,  0,  4'h0, 4'h0, 3, 3, 16'h0000,16'h0000,16'h0000,16'hFFFF,4'h0};
    tbl[6]  = '{0, 0, 16'h0000, 1,  1,  0,  4'h0, 4'h0, 3, 3, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,4'h0};
    tbl[7]  = '{1, 3, 16'h0100, 1,  0,  0,  4'h0, 4'h0, 3, 3, 16'h0100,16'h0100,16'hFFFF,16'h0100,4'h0};
    tbl[8]  = '{0, 0, 16'h0000, 0,  0,  1,  4'hA, 4'hF, 1, 0, 16'h1234,16'h0000,16'h1234,16'h0100,4'hA};
    tbl[9]  = '{0, 0, 16'h0000, 0,  0,  1,  4'h5, 4'h3, 1, 0, 16'h1234,16'h0000,16'h1234,16'h0100,4'h9};
    tbl[10] = '{0, 0, 16'h0000, 0,  0,  0,  4'hF, 4'hF, 1, 0, 16'h1234,16'h0000,16'h1234,16'h0100,4'h9};
    tbl[11] = '{1, 2, 16'hABCD, 1,  0,  0,  4'h0, 4'h0, 2, 3, 16'hABCD,16'h0100,16'h0000,16'h0101,4'h9};

    idle_in();
    #1 rst = 1;
    #1;
    check("rst_busy", {31'h0, ctx_busy}, 32'd0);
    check("rst_done", {31'h0, ctx_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 0;
    read_all(e_rst, "rst_read");
    check("rst_flags", {28'h0, flags_out}, 32'h0);
    check("rst_sp", {16'h0, sp_out}, 32'hFF00);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_in();
      wr_en = tbl[i].wr_en; wr_sel = tbl[i].wr_sel; wr_data = tbl[i].wr_data;
      sp_inc = tbl[i].inc; sp_dec = tbl[i].dec; flag_we = tbl[i].fwe;
      flag_in = tbl[i].fin; flag_mask = tbl[i].fmask;
      rd_sel_a = tbl[i].ra; rd_sel_b = tbl[i].rb;
      #1;
      check($sformatf("v%0d_rda", i), {16'h0, rd_data_a}, {16'h0, tbl[i].ea});
      check($sformatf("v%0d_rdb", i), {16'h0, rd_data_b}, {16'h0, tbl[i].eb});
      check($sformatf("v%0d_rda_nobyp", i), {16'h0, rd_data_a0}, {16'h0, tbl[i].ea0});
      expect_after(0, {16'h0, tbl[i].esp}, $sformatf("v%0d_sp", i));
      expect_after(1, {28'h0, tbl[i].efl}, $sformatf("v%0d_flags", i));
      tick();
    end

    // save, clobber, restore
    write_all(v11);
    read_all(v11, "load");
    run_ctx(1, 0, 16'h0055, "save");
    read_all(v11, "after_save");
    check("save_flags", {28'h0, flags_out}, 32'h9);
    check("save_sp", {16'h0, sp_out}, 32'h33);
    write_all(vee);
    @(negedge clk);
    flag_we = 1; flag_in = 4'h0; flag_mask = 4'hF;
    @(negedge clk);
    idle_in();
    read_all(vee, "clobber");
    run_ctx(0, 1, 16'hEE05, "restore");
    read_all(v11, "restored");
    check("restore_flags", {28'h0, flags_out}, 32'h9);

    // save and restore together: save wins
    write_all(vee);
    run_ctx(1, 1, 16'hEE05, "both");
    read_all(vee, "both_live");
    write_all(v11);
    run_ctx(0, 1, 16'h0055, "restore2");
    read_all(vee, "both_shadow");

    // reset in the middle of a save, once idx has reached 3
    write_all(v11);
    @(negedge clk);
    ctx_save = 1;
    @(negedge clk);
    idle_in();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_busy_pre", {31'h0, ctx_busy}, 32'd1);
    rst = 1;
    #1;
    check("midrst_busy", {31'h0, ctx_busy}, 32'd0);
    @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      expect_after(2, 32'd0, "midrst_busy_after");
      expect_after(3, 32'd0, "midrst_done_after");
      tick();
    end
    read_all(e_rst, "midrst_live");
    check("midrst_flags", {28'h0, flags_out}, 32'h0);
    write_all(v11);
    @(negedge clk);
    flag_we = 1; flag_in = 4'hF; flag_mask = 4'hF;
    @(negedge clk);
    idle_in();
    run_ctx(0, 1, 16'h0055, "midrst_restore");
    read_all(e_rst, "midrst_shadow");
    check("midrst_shadow_flags", {28'h0, flags_out}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
